fetch_ctrl: RTL and testbench

FETCH_CTRL -- requirements
Module: fetch_ctrl

---
 rtl/fetch_ctrl.sv | 101 ++++++++++
 tb/tb_fetch_ctrl.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: requests one instruction at the current PC, holds it
// for decode until accepted, then steps the PC (sequential or branch target).
module fetch_ctrl #(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] PC,
  output logic             PCsrc,
  output logic             pc_en,
  output logic             imem_req,
  output logic [WIDTH-1:0] imem_addr,
  input  logic             imem_ack,
  input  logic [31:0]      imem_rdata,
  output logic [31:0]      instr,
  output logic             instr_valid,
  input  logic             stall,
  input  logic             branch_taken,
  input  logic             halt,
  output logic             fetch_err,
  output logic [31:0]      retire_cnt
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_ISSUE,
    S_HALTED,
    S_ERROR
  } state_t;

  state_t           state_q, state_d;
  logic [31:0]      instr_q, instr_d;
  logic [31:0]      retire_q, retire_d;
  logic [CNT_W-1:0] to_cnt_q, to_cnt_d;
  logic             aligned;
  logic             accept;

  assign aligned = (PC[1:0] == 2'b00);
  assign accept  = (state_q == S_ISSUE) && !stall;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      instr_q  <= '0;
      retire_q <= '0;
      to_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      instr_q  <= instr_d;
      retire_q <= retire_d;
      to_cnt_q <= to_cnt_d;
    end
  end

  // The timeout counter is held at zero outside FETCH, so every FETCH entry starts from zero.
  always_comb begin
    state_d  = state_q;
    instr_d  = instr_q;
    retire_d = retire_q;
    to_cnt_d = '0;
    case (state_q)
      S_IDLE:   state_d = halt ? S_HALTED : S_FETCH;
      S_FETCH: begin
        if (!aligned) begin
          state_d = S_ERROR;
        end else if (imem_ack) begin
          instr_d = imem_rdata;
          state_d = S_ISSUE;
        end else if (to_cnt_q == CNT_W'(TIMEOUT - 1)) begin
          state_d = S_ERROR;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end
      S_ISSUE: begin
        if (!stall) begin
          retire_d = retire_q + 32'd1;
          state_d  = halt ? S_HALTED : S_FETCH;
        end
      end
      S_HALTED: if (!halt) state_d = S_FETCH;
      S_ERROR:  state_d = S_ERROR;
      default:  state_d = S_IDLE;
    endcase
  end

  // Outputs decode from reset-cleared state, so they drop together with rst.
  assign imem_req    = (state_q == S_FETCH) && aligned;
  assign imem_addr   = imem_req ? PC : '0;
  assign pc_en       = accept;
  assign PCsrc       = accept && branch_taken;
  assign instr_valid = (state_q == S_ISSUE);
  assign fetch_err   = (state_q == S_ERROR);
  assign instr       = instr_q;
  assign retire_cnt  = retire_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed fetch sequences with a scoreboard of expected
// instructions and PC-select values, consumed whenever the controller pulses pc_en.
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] PC;
  logic        PCsrc;
  logic        pc_en;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic        instr_valid;
  logic        stall;
  logic        branch_taken;
  logic        halt;
  logic        fetch_err;
  logic [31:0] retire_cnt;

  int          n_chk  = 0;
  int          n_fail = 0;
  logic [32:0] sbq[$];
  logic [31:0] exp_retire = 32'd0;

  fetch_ctrl #(.WIDTH(32), .TIMEOUT(15)) dut (
    .clk(clk), .rst(rst), .PC(PC), .PCsrc(PCsrc), .pc_en(pc_en),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .instr(instr), .instr_valid(instr_valid),
    .stall(stall), .branch_taken(branch_taken), .halt(halt),
    .fetch_err(fetch_err), .retire_cnt(retire_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard consumer: sampled mid-cycle, after the drivers have settled.
  always begin
    logic [32:0] e;
    @(negedge clk);
    #3;
    if (rst && pc_en) begin
      if (sbq.size() == 0) begin
        chk("sb_underflow", 64'd1, 64'd0);
      end else begin
        e = sbq.pop_front();
        chk("sb_instr", 64'(instr), 64'(e[31:0]));
        chk("sb_pcsrc", 64'(PCsrc), 64'(e[32]));
        chk("sb_retire_pre", 64'(retire_cnt), 64'(exp_retire));
        exp_retire = exp_retire + 32'd1;
      end
    end
  end

  task automatic do_reset();
    rst = 1'b0; PC = '0; imem_ack = 1'b0; imem_rdata = '0;
    stall = 1'b0; branch_taken = 1'b0; halt = 1'b0;
    sbq.delete();
    exp_retire = 32'd0;
    @(negedge clk); @(negedge clk); #1;
    chk("rst_req", 64'(imem_req), 64'd0);
    chk("rst_addr", 64'(imem_addr), 64'd0);
    chk("rst_instr", 64'(instr), 64'd0);
    chk("rst_valid", 64'(instr_valid), 64'd0);
    chk("rst_pcen", 64'(pc_en), 64'd0);
    chk("rst_pcsrc", 64'(PCsrc), 64'd0);
    chk("rst_err", 64'(fetch_err), 64'd0);
    chk("rst_retire", 64'(retire_cnt), 64'd0);
    rst = 1'b1;
    #1 chk("idle_req", 64'(imem_req), 64'd0);
  endtask

  // One complete transaction, starting with the controller in FETCH at the next negedge.
  task automatic fetch_one(input logic [31:0] pc, input int waits, input logic [31:0] rdata,
                           input logic br, input int nstall, input logic hlt);
    for (int i = 0; i < waits; i++) begin
      @(negedge clk);
      PC = pc; imem_ack = 1'b0;
      #1;
      chk("fetch_req", 64'(imem_req), 64'd1);
      chk("fetch_addr", 64'(imem_addr), 64'(pc));
      chk("fetch_pcen", 64'(pc_en), 64'd0);
      chk("fetch_pcsrc", 64'(PCsrc), 64'd0);
    end
    @(negedge clk);
    PC = pc; imem_ack = 1'b1; imem_rdata = rdata;
    sbq.push_back({br, rdata});
    #1 chk("ack_req", 64'(imem_req), 64'd1);
    @(negedge clk);
    imem_ack = 1'b1; imem_rdata = ~rdata;
    branch_taken = br; stall = (nstall > 0); halt = hlt;
    for (int i = 0; i < nstall; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      chk("stall_valid", 64'(instr_valid), 64'd1);
      chk("stall_instr", 64'(instr), 64'(rdata));
      chk("stall_pcen", 64'(pc_en), 64'd0);
      chk("stall_pcsrc", 64'(PCsrc), 64'd0);
    end
    if (nstall > 0) begin
      @(negedge clk);
      stall = 1'b0;
    end
    imem_ack = 1'b0;
    #1;
    chk("acc_valid", 64'(instr_valid), 64'd1);
    chk("acc_pcen", 64'(pc_en), 64'd1);
    chk("acc_pcsrc", 64'(PCsrc), 64'(br));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    do_reset();

    // Sequential fetch, then a stalled taken branch; branch_taken stays high into FETCH.
    fetch_one(32'h0, 2, 32'h00500093, 1'b0, 0, 1'b0);
    @(negedge clk); #1 chk("retire_1", 64'(retire_cnt), 64'd1);
    fetch_one(32'h4, 1, 32'h00A00113, 1'b1, 3, 1'b0);
    fetch_one(32'h40, 0, 32'hDEADBEEF, 1'b0, 1, 1'b0);
    fetch_one(32'h44, 14, 32'h12345678, 1'b1, 0, 1'b0);

    // Halt raised during a stalled ISSUE.
    fetch_one(32'h48, 1, 32'hCAFEF00D, 1'b0, 2, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      chk("halted_req", 64'(imem_req), 64'd0);
      chk("halted_valid", 64'(instr_valid), 64'd0);
    end
    @(negedge clk); halt = 1'b0;
    #1 chk("halted_exit_req", 64'(imem_req), 64'd0);
    fetch_one(32'h4C, 1, 32'h0000006F, 1'b0, 0, 1'b0);
    @(negedge clk); #1 chk("retire_6", 64'(retire_cnt), 64'd6);

    // Counter wrap from a forced all-ones value.
    force dut.retire_q = 32'hFFFFFFFF;
    #1 release dut.retire_q;
    exp_retire = 32'hFFFFFFFF;
    fetch_one(32'h50, 0, 32'h00000013, 1'b0, 0, 1'b0);
    @(negedge clk); #1 chk("retire_wrap", 64'(retire_cnt), 64'd0);

    // Reset in the middle of FETCH.
    PC = 32'h54; imem_ack = 1'b0;
    #1 chk("midfetch_req_pre", 64'(imem_req), 64'd1);
    rst = 1'b0;
    #1;
    chk("midfetch_req", 64'(imem_req), 64'd0);
    chk("midfetch_addr", 64'(imem_addr), 64'd0);
    chk("midfetch_instr", 64'(instr), 64'd0);
    chk("midfetch_retire", 64'(retire_cnt), 64'd0);
    do_reset();

    // Reset in the middle of a stalled ISSUE.
    @(negedge clk); PC = 32'h8; imem_ack = 1'b1; imem_rdata = 32'h11111111;
    @(negedge clk); imem_ack = 1'b0; stall = 1'b1;
    #1 chk("midissue_valid_pre", 64'(instr_valid), 64'd1);
    rst = 1'b0;
    #1;
    chk("midissue_valid", 64'(instr_valid), 64'd0);
    chk("midissue_pcen", 64'(pc_en), 64'd0);
    chk("midissue_instr", 64'(instr), 64'd0);
    do_reset();

    // Timeout: fifteen FETCH cycles without ack.
    for (int i = 0; i < 15; i++) begin
      @(negedge clk); PC = 32'h100; imem_ack = 1'b0;
      #1 chk("to_req", 64'(imem_req), 64'd1);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); imem_ack = i[0];
      #1;
      chk("to_err", 64'(fetch_err), 64'd1);
      chk("to_req_off", 64'(imem_req), 64'd0);
      chk("to_addr", 64'(imem_addr), 64'd0);
      chk("to_valid", 64'(instr_valid), 64'd0);
    end
    do_reset();

    // Misaligned PC in FETCH.
    @(negedge clk); PC = 32'h00000006; imem_ack = 1'b1;
    #1;
    chk("mis_req", 64'(imem_req), 64'd0);
    chk("mis_addr", 64'(imem_addr), 64'd0);
    chk("mis_err_pre", 64'(fetch_err), 64'd0);
    @(negedge clk); #1;
    chk("mis_err", 64'(fetch_err), 64'd1);
    chk("mis_req_err", 64'(imem_req), 64'd0);
    imem_ack = 1'b0;
    do_reset();

    chk("sb_drained", 64'(sbq.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
